// File: rtl/apb_ram_gen_pkg.sv
// Shared types and constants for the apb_ram_gen APB4 slave RAM.
//   state_t     : transfer FSM states
//   RESP_*      : pslverr encodings
//   WAIT_W      : wait-state counter width
//   lsb_of()    : byte-offset width for a given data bus width
package apb_ram_gen_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    localparam int unsigned WAIT_W = 4;

    // Number of byte-offset address bits below the word index.
    function automatic int unsigned lsb_of(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_ram_gen_mem.sv
// Single-port RAM with byte-lane write enables. Synchronous write,
// combinational read of the currently addressed word. Contents are not reset.
// Ports:
//   clk     : clock
//   we      : write enable
//   be      : byte-lane enables (one per 8-bit lane)
//   addr    : word index
//   wdata   : write data
//   rdata_c : read data of mem[addr] (combinational)
module apb_ram_gen_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                                         clk,
    input  logic                                         we,
    input  logic [DATA_WIDTH/8-1:0]                      be,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]                        wdata,
    output logic [DATA_WIDTH-1:0]                        rdata_c
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/apb_ram_gen.sv
// APB4 slave RAM with configurable width, depth and wait states, byte strobes,
// alignment/range error responses and abort handling.
// Optional macro APB_RAM_GEN_PROT_EN adds pprot and PROT_BASE: unprivileged
// writes (pprot[0]=0) to word index >= PROT_BASE get an error response.
// Ports:
//   pclk, presetn          : clock, async active-low reset
//   psel, penable, pwrite  : APB control
//   paddr                  : byte address
//   pwdata, pstrb          : write data and byte strobes
//   pprot                  : protection (only with APB_RAM_GEN_PROT_EN)
//   prdata, pready, pslverr: registered response
module apb_ram_gen
    import apb_ram_gen_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_CYCLES = 0
`ifdef APB_RAM_GEN_PROT_EN
    ,
    parameter int unsigned PROT_BASE   = DEPTH / 2
`endif
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
`ifdef APB_RAM_GEN_PROT_EN
    input  logic [2:0]              pprot,
`endif
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int unsigned NB  = DATA_WIDTH / 8;
    localparam int unsigned LSB = lsb_of(DATA_WIDTH);
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [63:0]           MEM_BYTES  = 64'(DEPTH) * 64'(NB);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB - 1);

    state_t                  state_q, state_d;
    logic [WAIT_W-1:0]       cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           strb_q, strb_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   prdata_d;
    logic                    pready_d, pslverr_d;

    logic [IW-1:0]           setup_idx_c;
    logic                    setup_err_c;
    logic                    prot_err_c;
    logic                    mem_we_c;
    logic [IW-1:0]           mem_addr_c;
    logic [DATA_WIDTH-1:0]   mem_rdata_c;

    // Address decode and error classification of the current setup phase
    assign setup_idx_c = paddr[LSB +: IW];

`ifdef APB_RAM_GEN_PROT_EN
    assign prot_err_c = pwrite && !pprot[0] && (32'(setup_idx_c) >= PROT_BASE);
`else
    assign prot_err_c = 1'b0;
`endif

    assign setup_err_c = (|(paddr & ALIGN_MASK))
                       || (64'(paddr) >= MEM_BYTES)
                       || prot_err_c;

    // In IDLE the port serves the setup read; in ACCESS it holds the latched index for the write
    assign mem_addr_c = (state_q == ACCESS) ? idx_q : setup_idx_c;

    apb_ram_gen_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (pclk),
        .we      (mem_we_c),
        .be      (strb_q),
        .addr    (mem_addr_c),
        .wdata   (wdata_q),
        .rdata_c (mem_rdata_c)
    );

    // State and response registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            err_q   <= err_d;
            prdata  <= prdata_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
        end
    end

    // Next-state, wait counting and response generation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        err_d     = err_q;
        prdata_d  = prdata;
        pready_d  = pready;
        pslverr_d = pslverr;
        mem_we_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // penable without a preceding setup is ignored
                if (psel && !penable) begin
                    state_d  = ACCESS;
                    wr_d     = pwrite;
                    idx_d    = setup_idx_c;
                    wdata_d  = pwdata;
                    strb_d   = pstrb;
                    err_d    = setup_err_c;
                    cnt_d    = WAIT_W'(WAIT_CYCLES);
                    prdata_d = (!pwrite && !setup_err_c) ? mem_rdata_c : '0;
                    if (WAIT_CYCLES == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = setup_err_c ? RESP_ERROR : RESP_OKAY;
                    end
                end
            end

            ACCESS: begin
                if (!psel) begin
                    // Abort: drop the transfer without touching memory
                    state_d   = IDLE;
                    prdata_d  = '0;
                    pready_d  = 1'b0;
                    pslverr_d = RESP_OKAY;
                end else if (penable) begin
                    if (pready) begin
                        mem_we_c  = wr_q && !err_q;
                        state_d   = IDLE;
                        prdata_d  = '0;
                        pready_d  = 1'b0;
                        pslverr_d = RESP_OKAY;
                    end else begin
                        cnt_d = cnt_q - WAIT_W'(1);
                        if (cnt_q == WAIT_W'(1)) begin
                            pready_d  = 1'b1;
                            pslverr_d = err_q ? RESP_ERROR : RESP_OKAY;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_ram_gen.sv
module tb_apb_ram_gen;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          waits;
    } exp_t;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel0, psel2, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
`ifdef APB_RAM_GEN_PROT_EN
    logic [2:0]  pprot;
`endif
    logic [31:0] prdata0, prdata2;
    logic        pready0, pready2, pslverr0, pslverr2;
    logic        use2;

    logic        psel_m, pready_m, pslverr_m;
    logic [31:0] prdata_m;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    always #5 pclk = ~pclk;

    assign psel_m    = use2 ? psel2    : psel0;
    assign pready_m  = use2 ? pready2  : pready0;
    assign pslverr_m = use2 ? pslverr2 : pslverr0;
    assign prdata_m  = use2 ? prdata2  : prdata0;

    apb_ram_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(32), .WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
`ifdef APB_RAM_GEN_PROT_EN
        .pprot(pprot),
`endif
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_ram_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(32), .WAIT_CYCLES(2)) dut2 (
        .pclk(pclk), .presetn(presetn), .psel(psel2), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
`ifdef APB_RAM_GEN_PROT_EN
        .pprot(pprot),
`endif
        .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every cycle the selected slave shows pready
    int   waits = 0;
    exp_t e;
    always @(negedge pclk) begin
        if (psel_m && !penable) begin
            waits = 0;
        end else if (psel_m && penable) begin
            if (!pready_m) begin
                waits++;
            end else begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pready: got pready=1 want no transfer at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("prdata",  prdata_m, e.rd);
                    chk("pslverr", 32'(pslverr_m), 32'(e.err));
                    chk("waits",   32'(waits), 32'(e.waits));
                end
                waits = 0;
            end
        end
    end

    task automatic push(input logic u2, input logic [31:0] er, input logic ee);
        exp_t x;
        x.rd    = er;
        x.err   = ee;
        x.waits = u2 ? 2 : 0;
        q.push_back(x);
    endtask

    task automatic setup(input logic u2, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        use2    = u2;
        psel0   = !u2;
        psel2   = u2;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        @(posedge pclk); #1;
        penable = 1'b1;
    endtask

    // Wait (bounded) for pready at a sampling point; ok=0 on timeout
    task automatic wait_ready(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge pclk);
            if (pready_m) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL timeout: got no pready want pready within 20 cycles at %0t", $time);
            void'(q.pop_back());
        end
    endtask

    // Full transfer; leaves the bus selected so the next call is back-to-back
    task automatic xfer(input logic u2, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] er, input logic ee);
        logic ok;
        push(u2, er, ee);
        setup(u2, wr, a, d, s);
        wait_ready(ok);
        if (ok) begin
            @(posedge pclk); #1;
        end else begin
            psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
            @(posedge pclk); #1;
        end
    endtask

    task automatic bus_idle();
        psel0   = 1'b0;
        psel2   = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        presetn = 1'b0;
        psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; use2 = 1'b0;
`ifdef APB_RAM_GEN_PROT_EN
        pprot = 3'b001;
`endif
        #12;
        chk("rst_pready0",  32'(pready0),  32'd0);
        chk("rst_pslverr0", 32'(pslverr0), 32'd0);
        chk("rst_prdata0",  prdata0,       32'd0);
        chk("rst_pready2",  32'(pready2),  32'd0);
        chk("rst_prdata2",  prdata2,       32'd0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;

        // Zero-wait slave: basic, strobes, errors
        xfer(1'b0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        xfer(1'b0, 1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
        xfer(1'b0, 1'b1, 32'h08, 32'h11223344, 4'hF, 32'h0, 1'b0);
        xfer(1'b0, 1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0);
        xfer(1'b0, 1'b0, 32'h08, 32'h0,        4'h0, 32'h11BB33DD, 1'b0);
        xfer(1'b0, 1'b0, 32'h80, 32'h0,        4'h0, 32'h0, 1'b1);
        xfer(1'b0, 1'b1, 32'h06, 32'h55555555, 4'hF, 32'h0, 1'b1);
        bus_idle();

        // penable without setup must be ignored
        use2 = 1'b0; psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 32'h04; pwdata = 32'h0; pstrb = 4'hF;
        repeat (2) @(posedge pclk);
        #1;
        chk("viol_pready", 32'(pready0), 32'd0);
        bus_idle();

        xfer(1'b0, 1'b1, 32'h04, 32'h0,        4'h0, 32'h0, 1'b0);
        xfer(1'b0, 1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
        xfer(1'b0, 1'b1, 32'h7C, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        xfer(1'b0, 1'b0, 32'h7C, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0);
        bus_idle();

        // Two-wait slave: back-to-back write/read and an error
        xfer(1'b1, 1'b1, 32'h0C, 32'h12345678, 4'hF, 32'h0, 1'b0);
        xfer(1'b1, 1'b0, 32'h0C, 32'h0,        4'h0, 32'h12345678, 1'b0);
        xfer(1'b1, 1'b0, 32'h80, 32'h0,        4'h0, 32'h0, 1'b1);
        bus_idle();

        // Abort a write after one access cycle
        setup(1'b1, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'hF);
        @(posedge pclk); #1;
        psel2 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        chk("abort_pready", 32'(pready2), 32'd0);
        xfer(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 32'h12345678, 1'b0);
        bus_idle();

        // Async reset while a read is presenting data
        push(1'b1, 32'h12345678, 1'b0);
        setup(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
        wait_ready(ok);
        #1 presetn = 1'b0;
        #1;
        chk("arst_pready",  32'(pready2),  32'd0);
        chk("arst_pslverr", 32'(pslverr2), 32'd0);
        chk("arst_prdata",  prdata2,       32'd0);
        psel2 = 1'b0; penable = 1'b0;
        #1 presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 32'h12345678, 1'b0);
        xfer(1'b0, 1'b0, 32'h04, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        bus_idle();

`ifdef APB_RAM_GEN_PROT_EN
        // Index 20 lies above the default protection base of 16
        pprot = 3'b001;
        xfer(1'b0, 1'b1, 32'h50, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
        pprot = 3'b000;
        xfer(1'b0, 1'b1, 32'h50, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b1);
        xfer(1'b0, 1'b0, 32'h50, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0);
        pprot = 3'b001;
        bus_idle();
`endif

        repeat (3) @(posedge pclk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
